multicycle_control_unit: RTL
============================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter BRANCH_EXT, default 1, meaning: 1 enables beq/bne/blt/bge resolution, 0 resolves beq only.
REQ-002 SHALL have parameter ALU_CTRL_W, default 3, meaning: ALUControl width (>=3); bits above [2:0] driven 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Op  input  7  instruction opcode from instruction register.
REQ-006 SHALL have port funct3  input  3  instruction funct3.
REQ-007 SHALL have port funct7  input  1  instruction bit 30.
REQ-008 SHALL have port Zero, Negative, Overflow  input  1 each  ALU flags from the current cycle.
REQ-009 SHALL have port MemReady  input  1  memory handshake; 1 = access completes this cycle.
REQ-010 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-011 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-012 SHALL have output ALUControl  output  ALU_CTRL_W  ALU operation.
REQ-013 SHALL have output IllegalOp  output  1  registered one-cycle pulse on an unsupported opcode.
REQ-014 SHALL have output State  output  4  current FSM state encoding, for debug.

Function
REQ-015 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10; codes 11-15 unreachable, decoded as FETCH with next state FETCH.
REQ-016 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=MemReady; stays in FETCH while MemReady=0, else DECODE.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by Op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH, 1101111->JAL, any other->FETCH with IllegalOp=1 in the following cycle.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; Op[5]=0->MEMREAD, Op[5]=1->MEMWRITE.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady=1, then MEMWB.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1; ->FETCH.
REQ-021 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in state; hold until MemReady=1, then FETCH.
REQ-022 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: same but ALUSrcB=01; both ->ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1; ->FETCH.
REQ-024 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=taken; ->FETCH.
REQ-025 taken with BRANCH_EXT=1: funct3 000 Zero, 001 !Zero, 100 Negative^Overflow, 101 !(Negative^Overflow), other codes 0; with BRANCH_EXT=0: taken=Zero for any funct3.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; ->ALUWB.
REQ-027 Every output not listed for a state SHALL be 0 in that state.
REQ-028 ImmSrc SHALL be combinational from Op in all states: 0100011->01, 1100011->10, 1101111->11, otherwise 00.
REQ-029 ALUControl: ALUOp 00->000 (add), 01->001 (sub); 10 by funct3: 000 -> 001 if {Op[5],funct7}=11, else 000; 010->101 (slt); 110->011 (or); 111->010 (and); other funct3->000.
REQ-030 MemReady SHALL be ignored outside FETCH, MEMREAD and MEMWRITE.

Reset
REQ-031 rst=0 SHALL immediately force state FETCH and IllegalOp=0, independent of clk.
REQ-032 While rst=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0 regardless of MemReady; other outputs take FETCH values.
REQ-033 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL abort it; first post-reset cycle is FETCH.

Verification
REQ-034 R-type add: Op=0110011, MemReady=1 -> FETCH,DECODE,EXECUTER,ALUWB,FETCH; RegWrite=1 only in ALUWB; ALUControl=000 in EXECUTER.
REQ-035 lw, MemReady held 0 for 3 cycles in MEMREAD -> stays in MEMREAD 3 cycles with AdrSrc=1, then MEMWB with RegWrite=1, ResultSrc=01.
REQ-036 bne, funct3=001: Zero=0 -> PCWrite=1 in BRANCH; Zero=1 -> PCWrite=0; with BRANCH_EXT=0, Zero=0 -> PCWrite=0.
REQ-037 Op=1111111 in DECODE -> next state FETCH, IllegalOp=1 for exactly one cycle.
REQ-038 rst driven low between clock edges while in MEMWRITE -> State=0 and MemWrite=0 before next edge; after release, FETCH with IRWrite=MemReady.
REQ-039 sub: Op=0110011, funct3=000, funct7=1 -> ALUControl=001; addi with funct7=1 -> ALUControl=000.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle control unit (master) and its datapath (slave).
interface multicycle_control_unit_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [6:0]            Op;
  logic [2:0]            funct3;
  logic                  funct7;
  logic                  Zero;
  logic                  Negative;
  logic                  Overflow;
  logic                  MemReady;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  RegWrite;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  IllegalOp;
  logic [3:0]            State;

  modport master (
    input  Op, funct3, funct7, Zero, Negative, Overflow, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
  );

  modport slave (
    output Op, funct3, funct7, Zero, Negative, Overflow, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a multicycle RV32 subset datapath with a memory
// ready handshake, optional extended branch resolution and illegal-opcode flag.
module multicycle_control_unit #(
    parameter int BRANCH_EXT = 1,
    parameter int ALU_CTRL_W = 3
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       pcw, adr, memw, irw, regw, taken;
    logic [1:0] rsrc, srca, srcb, aluop;
    logic [2:0] alu_ctl;
    logic [ALU_CTRL_W-1:0] alu_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        taken = bus.Zero;
        if (BRANCH_EXT != 0) begin
            case (bus.funct3)
                3'b000:  taken = bus.Zero;
                3'b001:  taken = !bus.Zero;
                3'b100:  taken = bus.Negative ^ bus.Overflow;
                3'b101:  taken = !(bus.Negative ^ bus.Overflow);
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        pcw = 1'b0; adr = 1'b0; memw = 1'b0; irw = 1'b0; regw = 1'b0;
        rsrc = 2'b00; srca = 2'b00; srcb = 2'b00; aluop = 2'b00;
        case (state_q)
            S_FETCH: begin
                srcb = 2'b10; rsrc = 2'b10;
                irw  = bus.MemReady; pcw = bus.MemReady;
                state_d = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                srca = 2'b01; srcb = 2'b01;
                case (bus.Op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECUTER;
                    7'b0010011:             state_d = S_EXECUTEI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    default:                illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: begin
                srca = 2'b10; srcb = 2'b01;
                state_d = bus.Op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr = 1'b1;
                state_d = bus.MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                rsrc = 2'b01; regw = 1'b1;
            end
            S_MEMWRITE: begin
                adr = 1'b1; memw = 1'b1;
                state_d = bus.MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI: begin
                srca  = 2'b10; aluop = 2'b10;
                srcb  = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                state_d = S_ALUWB;
            end
            S_ALUWB: regw = 1'b1;
            S_BRANCH: begin
                srca = 2'b10; aluop = 2'b01; pcw = taken;
            end
            S_JAL: begin
                srca = 2'b01; srcb = 2'b10; pcw = 1'b1;
                state_d = S_ALUWB;
            end
            // Unused encodings present FETCH outputs but never leave FETCH on the next edge.
            default: begin
                srcb = 2'b10; rsrc = 2'b10;
                irw  = bus.MemReady; pcw = bus.MemReady;
            end
        endcase
    end

    always_comb begin
        alu_ctl = 3'b000;
        case (aluop)
            2'b01: alu_ctl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_ctl = ({bus.Op[5], bus.funct7} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctl = 3'b101;
                    3'b110:  alu_ctl = 3'b011;
                    3'b111:  alu_ctl = 3'b010;
                    default: alu_ctl = 3'b000;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
        alu_full      = '0;
        alu_full[2:0] = alu_ctl;
    end

    always_comb begin
        case (bus.Op)
            7'b0100011: bus.ImmSrc = 2'b01;
            7'b1100011: bus.ImmSrc = 2'b10;
            7'b1101111: bus.ImmSrc = 2'b11;
            default:    bus.ImmSrc = 2'b00;
        endcase
    end

    // Write strobes are gated by reset directly so they drop without waiting for a clock.
    assign bus.PCWrite    = pcw  & rst;
    assign bus.IRWrite    = irw  & rst;
    assign bus.MemWrite   = memw & rst;
    assign bus.RegWrite   = regw & rst;
    assign bus.AdrSrc     = adr;
    assign bus.ResultSrc  = rsrc;
    assign bus.ALUSrcA    = srca;
    assign bus.ALUSrcB    = srcb;
    assign bus.ALUControl = alu_full;
    assign bus.IllegalOp  = illegal_q;
    assign bus.State      = state_q;

endmodule
